// File: rtl/ctrl_fsm_param_if.sv
// rtl/ctrl_fsm_param_if.sv - control/status bundle between the FIFO array supervisor and ctrl_fsm_param
interface ctrl_fsm_param_if #(
    parameter int N_FIFOS   = 5,
    parameter int UMB_W     = 2,
    parameter int ERR_CNT_W = 4
);
    logic                 init;
    logic                 clear_err;
    logic [UMB_W-1:0]     Umbrales_MFs;
    logic [UMB_W-1:0]     Umbrales_VCs;
    logic [UMB_W-1:0]     Umbrales_Ds;
    logic [N_FIFOS-1:0]   FIFO_empties;
    logic [N_FIFOS-1:0]   FIFO_errors;
    logic [N_FIFOS-1:0]   err_mask;
    logic [UMB_W-1:0]     Umbrales_MFs_internos;
    logic [UMB_W-1:0]     Umbrales_VCs_internos;
    logic [UMB_W-1:0]     Umbrales_Ds_internos;
    logic [4:0]           state_out;
    logic                 idle_out;
    logic                 active_out;
    logic                 error_out;
    logic [N_FIFOS-1:0]   err_src;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output init, clear_err, Umbrales_MFs, Umbrales_VCs, Umbrales_Ds,
               FIFO_empties, FIFO_errors, err_mask,
        input  Umbrales_MFs_internos, Umbrales_VCs_internos, Umbrales_Ds_internos,
               state_out, idle_out, active_out, error_out, err_src, err_count
    );

    modport slave (
        input  init, clear_err, Umbrales_MFs, Umbrales_VCs, Umbrales_Ds,
               FIFO_empties, FIFO_errors, err_mask,
        output Umbrales_MFs_internos, Umbrales_VCs_internos, Umbrales_Ds_internos,
               state_out, idle_out, active_out, error_out, err_src, err_count
    );
endinterface

// File: rtl/ctrl_fsm_param.sv
// rtl/ctrl_fsm_param.sv - parametrised FIFO-array control FSM with threshold hold and error capture
module ctrl_fsm_param #(
    parameter int N_FIFOS   = 5,
    parameter int UMB_W     = 2,
    parameter int IDLE_HOLD = 1,
    parameter int ERR_CNT_W = 4
) (
    input  logic           clk,
    input  logic           reset,
    ctrl_fsm_param_if.slave bus
);
    localparam int HOLD_W = $clog2(IDLE_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(IDLE_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(IDLE_HOLD);

    typedef enum logic [4:0] {
        S_RESET  = 5'b00001,
        S_INIT   = 5'b00010,
        S_IDLE   = 5'b00100,
        S_ACTIVE = 5'b01000,
        S_ERROR  = 5'b10000
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [HOLD_W-1:0]    hold_cnt;
    logic [UMB_W-1:0]     mf_q;
    logic [UMB_W-1:0]     vc_q;
    logic [UMB_W-1:0]     d_q;
    logic [N_FIFOS-1:0]   err_src_q;
    logic [ERR_CNT_W-1:0] err_count_q;

    logic [N_FIFOS-1:0]   merr;
    logic                 any_err;
    logic                 all_empty;

    assign merr      = bus.FIFO_errors & ~bus.err_mask;
    assign any_err   = |merr;
    assign all_empty = &bus.FIFO_empties;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_RESET;
        end else begin
            state <= next_state;
        end
    end

    // Illegal encodings fall through to the default arm and recover via RESET.
    always_comb begin
        next_state = S_RESET;
        case (state)
            S_RESET:  next_state = S_INIT;
            S_INIT:   next_state = bus.init ? S_INIT : S_IDLE;
            S_IDLE: begin
                if (bus.init)        next_state = S_INIT;
                else if (any_err)    next_state = S_ERROR;
                else if (!all_empty) next_state = S_ACTIVE;
                else                 next_state = S_IDLE;
            end
            S_ACTIVE: begin
                if (bus.init)                             next_state = S_INIT;
                else if (any_err)                         next_state = S_ERROR;
                else if (all_empty && hold_cnt == HOLD_LAST) next_state = S_IDLE;
                else                                      next_state = S_ACTIVE;
            end
            S_ERROR:  next_state = bus.clear_err ? S_INIT : S_ERROR;
            default:  next_state = S_RESET;
        endcase
    end

    always_comb begin
        bus.state_out  = state;
        bus.idle_out   = (state == S_IDLE);
        bus.active_out = (state == S_ACTIVE);
        bus.error_out  = (state == S_ERROR);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mf_q        <= '0;
            vc_q        <= '0;
            d_q         <= '0;
            hold_cnt    <= '0;
            err_src_q   <= '0;
            err_count_q <= '0;
        end else begin
            if (state == S_INIT) begin
                mf_q <= bus.Umbrales_MFs;
                vc_q <= bus.Umbrales_VCs;
                d_q  <= bus.Umbrales_Ds;
            end else if (state == S_RESET) begin
                mf_q <= '0;
                vc_q <= '0;
                d_q  <= '0;
            end

            // Counts consecutive all-empty cycles while ACTIVE is retained.
            if (state == S_ACTIVE && next_state == S_ACTIVE && all_empty) begin
                if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + HOLD_W'(1);
            end else begin
                hold_cnt <= '0;
            end

            if (state == S_ERROR) begin
                err_src_q <= bus.clear_err ? '0 : (err_src_q | merr);
            end else if (next_state == S_ERROR) begin
                err_src_q <= merr;
                if (err_count_q != '1) err_count_q <= err_count_q + ERR_CNT_W'(1);
            end
        end
    end

    assign bus.Umbrales_MFs_internos = mf_q;
    assign bus.Umbrales_VCs_internos = vc_q;
    assign bus.Umbrales_Ds_internos  = d_q;
    assign bus.err_src               = err_src_q;
    assign bus.err_count             = err_count_q;
endmodule

// File: tb/tb_ctrl_fsm_param.sv
// tb/tb_ctrl_fsm_param.sv - directed plus randomised bench for ctrl_fsm_param against a behavioural model
module tb_ctrl_fsm_param;
    localparam int N = 5;
    localparam int U = 2;
    localparam int H = 3;
    localparam int E = 4;
    localparam int CNT_MAX = (1 << E) - 1;

    localparam int M_RESET  = 0;
    localparam int M_INIT   = 1;
    localparam int M_IDLE   = 2;
    localparam int M_ACTIVE = 3;
    localparam int M_ERROR  = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ctrl_fsm_param_if #(.N_FIFOS(N), .UMB_W(U), .ERR_CNT_W(E)) bus ();

    ctrl_fsm_param #(.N_FIFOS(N), .UMB_W(U), .IDLE_HOLD(H), .ERR_CNT_W(E)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors = 0;
    int fails   = 0;

    int           m_st;
    logic [U-1:0] m_mf, m_vc, m_d;
    logic [N-1:0] m_src;
    int           m_cnt;
    int           m_run;
    bit           model_ok = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: named states, a run-length of empty cycles, sticky masks.
    always @(posedge clk) begin
        logic [N-1:0] merr;
        bit           anye;
        bit           alle;
        int           nxt;
        merr = bus.FIFO_errors & ~bus.err_mask;
        anye = (merr != '0);
        alle = (bus.FIFO_empties == {N{1'b1}});
        if (!reset) begin
            m_st = M_RESET; m_mf = '0; m_vc = '0; m_d = '0;
            m_src = '0; m_cnt = 0; m_run = 0; model_ok = 1'b1;
        end else if (model_ok) begin
            nxt = m_st;
            case (m_st)
                M_RESET: begin nxt = M_INIT; m_mf = '0; m_vc = '0; m_d = '0; end
                M_INIT: begin
                    m_mf = bus.Umbrales_MFs; m_vc = bus.Umbrales_VCs; m_d = bus.Umbrales_Ds;
                    nxt = bus.init ? M_INIT : M_IDLE;
                end
                M_IDLE: begin
                    if (bus.init) nxt = M_INIT;
                    else if (anye) nxt = M_ERROR;
                    else if (!alle) nxt = M_ACTIVE;
                end
                M_ACTIVE: begin
                    if (bus.init) nxt = M_INIT;
                    else if (anye) nxt = M_ERROR;
                    else if (alle) begin
                        m_run = m_run + 1;
                        if (m_run >= H) nxt = M_IDLE;
                    end else m_run = 0;
                end
                default: begin
                    if (bus.clear_err) begin nxt = M_INIT; m_src = '0; end
                    else m_src = m_src | merr;
                end
            endcase
            if (nxt == M_ERROR && m_st != M_ERROR) begin
                m_src = merr;
                m_cnt = (m_cnt >= CNT_MAX) ? CNT_MAX : m_cnt + 1;
            end
            if (nxt != M_ACTIVE) m_run = 0;
            m_st = nxt;
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("state_out",  32'(bus.state_out),  32'(1) << m_st);
            check("idle_out",   32'(bus.idle_out),   32'(m_st == M_IDLE));
            check("active_out", 32'(bus.active_out), 32'(m_st == M_ACTIVE));
            check("error_out",  32'(bus.error_out),  32'(m_st == M_ERROR));
            check("mf_int",     32'(bus.Umbrales_MFs_internos), 32'(m_mf));
            check("vc_int",     32'(bus.Umbrales_VCs_internos), 32'(m_vc));
            check("d_int",      32'(bus.Umbrales_Ds_internos),  32'(m_d));
            check("err_src",    32'(bus.err_src),   32'(m_src));
            check("err_count",  32'(bus.err_count), 32'(m_cnt));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pin_state(input string name, input logic [4:0] exp);
        check(name, 32'(bus.state_out), 32'(exp));
    endtask

    initial begin
        reset = 1'b0;
        bus.init = 1'b0; bus.clear_err = 1'b0;
        bus.Umbrales_MFs = 2'b01; bus.Umbrales_VCs = 2'b10; bus.Umbrales_Ds = 2'b11;
        bus.FIFO_empties = 5'b11111; bus.FIFO_errors = '0; bus.err_mask = '0;

        cyc(2);
        pin_state("pin_reset", 5'b00001);
        check("pin_reset_idle", 32'(bus.idle_out), 32'(0));
        check("pin_reset_cnt", 32'(bus.err_count), 32'(0));
        reset = 1'b1;
        cyc(1); pin_state("pin_init", 5'b00010);
        cyc(1); pin_state("pin_idle", 5'b00100);
        check("pin_idle_out", 32'(bus.idle_out), 32'(1));
        check("pin_mf", 32'(bus.Umbrales_MFs_internos), 32'(2'b01));
        check("pin_vc", 32'(bus.Umbrales_VCs_internos), 32'(2'b10));
        check("pin_d",  32'(bus.Umbrales_Ds_internos),  32'(2'b11));

        bus.FIFO_empties = 5'b11110; cyc(1); pin_state("pin_active", 5'b01000);
        bus.FIFO_empties = 5'b11111; cyc(2); pin_state("pin_hold2", 5'b01000);
        cyc(1); pin_state("pin_hold3_idle", 5'b00100);

        bus.FIFO_empties = 5'b11110; cyc(1);
        bus.FIFO_empties = 5'b11111; cyc(1);
        bus.FIFO_empties = 5'b11110; cyc(1);
        bus.FIFO_empties = 5'b11111; cyc(2); pin_state("pin_glitch_hold", 5'b01000);
        cyc(1); pin_state("pin_glitch_idle", 5'b00100);

        bus.FIFO_empties = 5'b11110; cyc(1);
        bus.FIFO_errors = 5'b00100; bus.err_mask = 5'b00100; cyc(1);
        pin_state("pin_masked", 5'b01000);
        bus.err_mask = '0; cyc(1);
        pin_state("pin_error", 5'b10000);
        check("pin_src1", 32'(bus.err_src), 32'(5'b00100));
        check("pin_cnt1", 32'(bus.err_count), 32'(1));
        bus.FIFO_errors = 5'b00001; cyc(1);
        check("pin_src_sticky", 32'(bus.err_src), 32'(5'b00101));
        bus.FIFO_errors = '0;

        bus.init = 1'b1; cyc(1); pin_state("pin_err_init_ign", 5'b10000);
        bus.init = 1'b0; bus.clear_err = 1'b1;
        bus.Umbrales_MFs = 2'b11; bus.Umbrales_VCs = 2'b00; bus.Umbrales_Ds = 2'b10;
        cyc(1); pin_state("pin_clear_init", 5'b00010);
        check("pin_src_clr", 32'(bus.err_src), 32'(0));
        bus.clear_err = 1'b0; bus.FIFO_empties = 5'b11111; cyc(1);
        pin_state("pin_reload_idle", 5'b00100);
        check("pin_mf2", 32'(bus.Umbrales_MFs_internos), 32'(2'b11));
        check("pin_d2",  32'(bus.Umbrales_Ds_internos),  32'(2'b10));
        check("pin_cnt_kept", 32'(bus.err_count), 32'(1));

        bus.init = 1'b1; bus.FIFO_errors = 5'b00001; bus.FIFO_empties = 5'b01111;
        cyc(1); pin_state("pin_init_wins", 5'b00010);
        cyc(1); pin_state("pin_init_held", 5'b00010);
        bus.init = 1'b0; bus.FIFO_errors = '0; bus.FIFO_empties = 5'b11111; cyc(1);

        repeat ((1 << E) + 1) begin
            bus.FIFO_errors = 5'b00001; cyc(1);
            bus.FIFO_errors = '0; bus.clear_err = 1'b1; cyc(1);
            bus.clear_err = 1'b0; cyc(1);
        end
        check("pin_cnt_sat", 32'(bus.err_count), 32'(CNT_MAX));

        bus.FIFO_empties = 5'b11110; cyc(1);
        reset = 1'b0; cyc(1);
        pin_state("pin_midreset", 5'b00001);
        check("pin_midreset_cnt", 32'(bus.err_count), 32'(0));
        check("pin_midreset_mf", 32'(bus.Umbrales_MFs_internos), 32'(0));
        check("pin_midreset_act", 32'(bus.active_out), 32'(0));
        reset = 1'b1; bus.FIFO_empties = 5'b11111;

        repeat (3000) begin
            reset            = ($urandom_range(0, 99) != 0);
            bus.init         = ($urandom_range(0, 15) == 0);
            bus.clear_err    = ($urandom_range(0, 3) == 0);
            bus.FIFO_errors  = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
            bus.err_mask     = N'($urandom);
            bus.FIFO_empties = ($urandom_range(0, 1) == 1) ? {N{1'b1}} : N'($urandom);
            bus.Umbrales_MFs = U'($urandom);
            bus.Umbrales_VCs = U'($urandom);
            bus.Umbrales_Ds  = U'($urandom);
            cyc(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
